// File: rtl/if_slice.sv
// if_slice: instruction-fetch stage feeding decode.
// Owns the fetch PC and keeps at most one request outstanding to a
// variable-latency instruction memory. Returned words land in a 2-entry
// prefetch buffer that is presented to decode as {PC_inc, instr} under a
// valid/stall handshake. A redirect from decode squashes all unconsumed work.
// Requests still in flight at the redirect are recognised by an epoch bit.
//
// Optional feature (macro IF_BYPASS_EN): when the buffer is empty, an
// accepted memory response is forwarded to decode in the same cycle.
// Leaving the macro undefined keeps decode fed purely from registers.

module if_slice #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        stall,
    input  logic        hlt,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic        out_valid,
    output logic [15:0] PC_inc,
    output logic [15:0] instr
);

    logic [15:0] fetch_pc;
    logic [15:0] req_pc;
    logic        outstanding;
    logic        epoch;
    logic        req_epoch;
    logic [1:0]  count;
    logic [31:0] entry0;
    logic [31:0] entry1;

    logic        ack_ok;
    logic        accept;
    logic        pop;
    logic        push;
    logic        bypass_take;
    logic        issue;
    logic [1:0]  count_after_pop;
    logic [31:0] push_data;

    // Handshake, buffer control and issue decisions
    always_comb begin
        // a stray ack with nothing outstanding is ignored
        ack_ok          = imem_ack && outstanding;
        // stale-epoch responses and responses racing a redirect are dropped
        accept          = ack_ok && (req_epoch == epoch) && !redirect;
        push_data       = {req_pc + 16'd1, imem_rdata};
        pop             = (count != 2'd0) && !stall && !redirect;
`ifdef IF_BYPASS_EN
        bypass_take     = accept && (count == 2'd0) && !stall;
        out_valid       = (count != 2'd0) || accept;
        {PC_inc, instr} = (count == 2'd0 && accept) ? push_data : entry0;
`else
        bypass_take     = 1'b0;
        out_valid       = (count != 2'd0);
        {PC_inc, instr} = entry0;
`endif
        push            = accept && !bypass_take;
        count_after_pop = count - {1'b0, pop};
        // the redirect cycle never issues: fetch_pc is being replaced
        issue           = rst && !outstanding && !hlt && !redirect
                          && (count_after_pop < 2'd2);
        imem_req        = outstanding || issue;
        imem_addr       = outstanding ? req_pc : fetch_pc;
    end

    // Fetch PC, request bookkeeping and epoch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            req_pc      <= RESET_PC;
            outstanding <= 1'b0;
            epoch       <= 1'b0;
            req_epoch   <= 1'b0;
        end else begin
            if (redirect) begin
                fetch_pc <= redirect_pc;
                epoch    <= ~epoch;
            end else if (issue) begin
                fetch_pc <= fetch_pc + 16'd1;
            end
            if (issue) begin
                req_pc      <= fetch_pc;
                req_epoch   <= epoch;
                outstanding <= 1'b1;
            end else if (ack_ok) begin
                outstanding <= 1'b0;
            end
        end
    end

    // Two-entry prefetch buffer; entry0 is always the head
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count  <= 2'd0;
            entry0 <= 32'd0;
            entry1 <= 32'd0;
        end else if (redirect) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) entry0 <= push_data;
                    else               entry1 <= push_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    entry0 <= entry1;
                    count  <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        entry0 <= push_data;
                    end else begin
                        entry0 <= entry1;
                        entry1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_if_slice.sv
// Bench for if_slice: behavioural variable-latency memory, a consumption
// scoreboard of expected {PC_inc, instr} words, and directed steps.
module tb_if_slice;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        stall;
    logic        hlt;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        out_valid;
    logic [15:0] PC_inc;
    logic [15:0] instr;

    int n_checks = 0;
    int n_errors = 0;
    int cons_cnt = 0;
    logic [15:0] last_exp = 16'h0;
    logic [31:0] sb_q[$];

    logic        mem_ack = 1'b0;
    logic        mem_busy = 1'b0;
    logic        stray_ack = 1'b0;
    logic [15:0] mem_a = 16'h0;
    logic [15:0] mem_rdata = 16'h0;
    int          mem_rem = 0;
    int          mem_lat = 1;

    assign imem_ack   = mem_ack | stray_ack;
    assign imem_rdata = mem_rdata;

    if_slice #(.RESET_PC(16'h0040)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .stall(stall), .hlt(hlt), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .out_valid(out_valid),
        .PC_inc(PC_inc), .instr(instr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] mem_f(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h3C5A;
    endfunction

    // memory responder: accepts on the falling edge, acks mem_lat cycles later
    always @(negedge clk) begin
        if (!rst) begin
            mem_ack  = 1'b0;
            mem_busy = 1'b0;
        end else begin
            if (mem_ack) begin
                mem_ack  = 1'b0;
                mem_busy = 1'b0;
            end
            if (mem_busy) begin
                mem_rem = mem_rem - 1;
                if (mem_rem == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_f(mem_a);
                end
            end else if (imem_req) begin
                mem_a    = imem_addr;
                mem_rem  = mem_lat;
                mem_busy = 1'b1;
            end
        end
    end

    // consumption monitor: every word decode takes must be the next expected one
    always @(negedge clk) begin
        logic [31:0] e;
        #3;
        if (rst && out_valid && !stall && !redirect) begin
            n_checks++;
            assert (sb_q.size() != 0) else begin
                n_errors++;
                $error("FAIL sb_unexpected: observed pc_inc=%h instr=%h, expected no output", PC_inc, instr);
            end
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                last_exp = e[31:16];
                cons_cnt++;
                assert ({PC_inc, instr} === e) else begin
                    n_errors++;
                    $error("FAIL sb_word: observed %h_%h, expected %h_%h", PC_inc, instr, e[31:16], e[15:0]);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic to_pos;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
        #1;
    endtask

    task automatic push_stream(input logic [15:0] start, input int n);
        logic [15:0] a;
        for (int i = 0; i < n; i++) begin
            a = start + 16'(i);
            sb_q.push_back({a + 16'd1, mem_f(a)});
        end
    endtask

    task automatic wait_cons(input int n, input string tag);
        int target;
        target = cons_cnt + n;
        for (int i = 0; i < 80; i++) begin
            to_pos();
            if (cons_cnt >= target) break;
        end
        check(tag, 32'(cons_cnt >= target), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 30; i++) begin
            smp();
            if (!imem_req) break;
            to_pos();
        end
        check(tag, 32'(imem_req), 32'd0);
    endtask

    initial begin
        int ones;
        logic stable;
        logic req_seen;
        int c0;
        logic found;

        rst = 1'b0; redirect = 1'b0; redirect_pc = 16'h0; stall = 1'b0; hlt = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'h0040);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_pcinc", 32'(PC_inc), 32'h0000);
        check("rst_instr", 32'(instr), 32'h0000);

        // first fetch straight after reset, then stall from first valid word
        to_pos();
        rst = 1'b1;
        push_stream(16'h0040, 10);
        smp();
        check("c0_req", 32'(imem_req), 32'd1);
        check("c0_addr", 32'(imem_addr), 32'h0040);
        check("c0_valid", 32'(out_valid), 32'd0);
        to_pos();
        stall = 1'b1;
        smp();
        check("c1_addr", 32'(imem_addr), 32'h0040);
`ifdef IF_BYPASS_EN
        check("c1_bypass_valid", 32'(out_valid), 32'd1);
        check("c1_bypass_pcinc", 32'(PC_inc), 32'h0041);
`else
        check("c1_valid", 32'(out_valid), 32'd0);
`endif
        to_pos();
        smp();
        check("c2_valid", 32'(out_valid), 32'd1);
        check("c2_pcinc", 32'(PC_inc), 32'h0041);
        check("c2_instr", 32'(instr), 32'(mem_f(16'h0040)));
        check("c2_req", 32'(imem_req), 32'd1);
        check("c2_addr", 32'(imem_addr), 32'h0041);
        stable = 1'b1;
        for (int i = 0; i < 9; i++) begin
            to_pos();
            smp();
            if (!(out_valid && PC_inc == 16'h0041 && instr == mem_f(16'h0040))) stable = 1'b0;
        end
        check("stall_stable", 32'(stable), 32'd1);
        check("stall_full_noreq", 32'(imem_req), 32'd0);
        to_pos();
        stall = 1'b0;
        wait_cons(3, "stall_release");

        // single-cycle memory gives one word every two cycles
        ones = 0;
        for (int i = 0; i < 10; i++) begin
            smp();
            if (out_valid) ones++;
            to_pos();
        end
        check("bandwidth", 32'(ones), 32'd5);

        // redirect while a 3-cycle request is in flight
        hlt = 1'b1;
        wait_idle("idle_before_r1");
        to_pos();
        redirect = 1'b1; redirect_pc = 16'h0005; hlt = 1'b0; mem_lat = 3;
        sb_q.delete();
        to_pos();
        redirect = 1'b0;
        smp();
        check("r1_req", 32'(imem_req), 32'd1);
        check("r1_addr", 32'(imem_addr), 32'h0005);
        check("r1_valid", 32'(out_valid), 32'd0);
        to_pos();
        redirect = 1'b1; redirect_pc = 16'h0100;
        push_stream(16'h0100, 10);
        to_pos();
        redirect = 1'b0;
        smp();
        check("inflight_addr", 32'(imem_addr), 32'h0005);
        to_pos();
        to_pos();
        smp();
        check("post_discard_req", 32'(imem_req), 32'd1);
        check("post_discard_addr", 32'(imem_addr), 32'h0100);
        wait_cons(3, "redirect_stream");

        // redirect coinciding with an ack while stalled with a buffered word
        hlt = 1'b1;
        wait_idle("idle_before_r2");
        to_pos();
        redirect = 1'b1; redirect_pc = 16'h0200; hlt = 1'b0; stall = 1'b1;
        sb_q.delete();
        to_pos();
        redirect = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            smp();
            if (mem_ack && mem_a == 16'h0201 && out_valid) begin
                found = 1'b1;
                break;
            end
            to_pos();
        end
        check("ack_redirect_found", 32'(found), 32'd1);
        redirect = 1'b1; redirect_pc = 16'h0300;
        sb_q.delete();
        push_stream(16'h0300, 10);
        to_pos();
        redirect = 1'b0;
        smp();
        check("ack_redirect_valid", 32'(out_valid), 32'd0);
        check("ack_redirect_addr", 32'(imem_addr), 32'h0300);
        to_pos();
        stall = 1'b0;
        wait_cons(3, "ack_redirect_stream");

        // PC wrap at the top of the address space
        redirect = 1'b1; redirect_pc = 16'hFFFF; mem_lat = 1;
        sb_q.delete();
        push_stream(16'hFFFF, 10);
        to_pos();
        redirect = 1'b0;
        wait_cons(2, "wrap_stream");

        // hlt with a request outstanding
        mem_lat = 3;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            smp();
            if (mem_busy && !mem_ack) begin
                found = 1'b1;
                break;
            end
            to_pos();
        end
        check("hlt_busy_found", 32'(found), 32'd1);
        to_pos();
        hlt = 1'b1;
        c0 = cons_cnt;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            smp();
            if (mem_ack) begin
                found = 1'b1;
                break;
            end
            to_pos();
        end
        check("hlt_ack_seen", 32'(found), 32'd1);
        req_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            to_pos();
            smp();
            if (imem_req) req_seen = 1'b1;
        end
        check("hlt_no_issue", 32'(req_seen), 32'd0);
        check("hlt_delivered", 32'(cons_cnt > c0), 32'd1);
        check("hlt_drained", 32'(out_valid), 32'd0);
        to_pos();
        hlt = 1'b0;
        smp();
        check("hlt_resume_req", 32'(imem_req), 32'd1);
        check("hlt_resume_addr", 32'(imem_addr), 32'(last_exp));

        // reset mid-request, then a stray ack
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            smp();
            if (mem_busy && !mem_ack) begin
                found = 1'b1;
                break;
            end
            to_pos();
        end
        check("rst2_busy_found", 32'(found), 32'd1);
        to_pos();
        rst = 1'b0;
        sb_q.delete();
        #1;
        check("rst2_req", 32'(imem_req), 32'd0);
        check("rst2_valid", 32'(out_valid), 32'd0);
        check("rst2_addr", 32'(imem_addr), 32'h0040);
        to_pos();
        hlt = 1'b1;
        to_pos();
        rst = 1'b1;
        stray_ack = 1'b1;
        smp();
        check("stray_req", 32'(imem_req), 32'd0);
        to_pos();
        stray_ack = 1'b0;
        smp();
        check("stray_valid", 32'(out_valid), 32'd0);
        check("stray_noreq", 32'(imem_req), 32'd0);
        to_pos();
        hlt = 1'b0;
        push_stream(16'h0040, 10);
        smp();
        check("rst2_restart_addr", 32'(imem_addr), 32'h0040);
        wait_cons(3, "rst2_stream");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
